// File: rtl/conv_out_buf_writer_pkg.sv
// Shared conv constants: output-buffer packing geometry and address width.
package conv_out_buf_writer_pkg;

   localparam int CONV_PIXELS_IN_ROW         = 32;
   localparam int CONV_PIXELS_IN_ROW_IN_2POW = 5;
   localparam int CONV_OUT_DATA_WIDTH        = 256;
   localparam int CONV_ADR_W                 = 16;

   typedef logic [CONV_ADR_W-1:0] adr_t;

endpackage

// File: rtl/conv_out_buf_writer_out_wr_fifo.sv
// Show-ahead circular FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable. A pop frees its slot in time for a push in the
// same cycle, so a full FIFO still accepts a beat while it is draining.
module out_wr_fifo #(
   parameter int width         = 273,
   parameter int depth         = 4,
   parameter int depth_in_2pow = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic             push_accepted
);

   logic [depth_in_2pow:0] wr_ptr;
   logic [depth_in_2pow:0] rd_ptr;
   logic [width-1:0]       mem [depth];
   logic                   do_push;
   logic                   do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[depth_in_2pow] != rd_ptr[depth_in_2pow]) &&
                  (wr_ptr[depth_in_2pow-1:0] == rd_ptr[depth_in_2pow-1:0]);

   assign do_pop        = pop && !empty;
   assign do_push       = push && (!full || do_pop);
   assign push_accepted = do_push;

   assign head_data = mem[rd_ptr[depth_in_2pow-1:0]];

   // Advance the write/read pointers on accepted pushes and pops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array; contents are only visible through the head when non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[depth_in_2pow-1:0]] <= push_data;
   end

endmodule

// File: rtl/conv_out_buf_writer.sv
// Conv output-buffer writer: registers handler beats, turns 1-based y/x/f
// coordinates into a buffer word address, and queues {end, adr, data} in a
// small elastic FIFO so a stalling write port never backpressures the
// handler. Tracks tile completion, beat count and sticky overflow.
module conv_out_buf_writer
   import conv_out_buf_writer_pkg::*;
#(
   parameter int pixels_in_row         = CONV_PIXELS_IN_ROW,
   parameter int pixels_in_row_in_2pow = CONV_PIXELS_IN_ROW_IN_2POW,
   parameter int out_data_width        = CONV_OUT_DATA_WIDTH,
   parameter int fifo_depth            = 4,
   parameter int fifo_depth_in_2pow    = 2
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [out_data_width-1:0] in_data,
   input  logic [15:0]               in_y_idx,
   input  logic [15:0]               in_x_idx,
   input  logic [15:0]               in_f_idx,
   input  logic                      in_add_end,
   input  logic [15:0]               of_in_2pow,
   input  logic [15:0]               ox_in_2pow,
   input  logic                      buf_wr_ready,
   output logic                      buf_wr_en,
   output logic [15:0]               buf_wr_adr,
   output logic [out_data_width-1:0] buf_wr_data,
   output logic                      tile_done,
   output logic                      overflow,
   output logic [15:0]               beats_written
);

   localparam int ENTRY_W = 1 + CONV_ADR_W + out_data_width;

   // Word address of a 1-based (y, x, f) coordinate. Rows span OF*OX/PIR
   // words, each PIR-wide x group spans OF words. Everything wraps mod 2^16.
   function automatic adr_t calc_adr(input adr_t y, input adr_t x, input adr_t f,
                                     input adr_t of2, input adr_t ox2);
      adr_t row_shift;
      adr_t x_group;
      row_shift = of2 + ox2 - adr_t'(pixels_in_row_in_2pow);
      x_group   = (x - 16'd1) / adr_t'(pixels_in_row);
      return ((y - 16'd1) << row_shift) + (x_group << of2) + (f - 16'd1);
   endfunction

   logic                      vld_p0;
   logic [out_data_width-1:0] data_p0;
   adr_t                      y_p0;
   adr_t                      x_p0;
   adr_t                      f_p0;
   logic                      end_p0;

   adr_t                      adr_p1;
   logic [ENTRY_W-1:0]        push_entry;
   logic [ENTRY_W-1:0]        head_entry;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      push_accepted;
   logic                      head_end;
   logic                      pop;

   // ---- stage A: capture the handler beat ----
   // Register the beat and its coordinates; the valid follows in_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         y_p0    <= '0;
         x_p0    <= '0;
         f_p0    <= '0;
         end_p0  <= 1'b0;
      end else begin
         vld_p0 <= in_valid;
         if (in_valid) begin
            data_p0 <= in_data;
            y_p0    <= in_y_idx;
            x_p0    <= in_x_idx;
            f_p0    <= in_f_idx;
            end_p0  <= in_add_end;
         end
      end
   end

   // ---- stage B: address and FIFO push ----
   assign adr_p1     = calc_adr(y_p0, x_p0, f_p0, of_in_2pow, ox_in_2pow);
   assign push_entry = {end_p0, adr_p1, data_p0};

   out_wr_fifo #(
      .width         (ENTRY_W),
      .depth         (fifo_depth),
      .depth_in_2pow (fifo_depth_in_2pow)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push          (vld_p0),
      .push_data     (push_entry),
      .pop           (pop),
      .head_data     (head_entry),
      .full          (fifo_full),
      .empty         (fifo_empty),
      .push_accepted (push_accepted)
   );

   // ---- write port: show-ahead head of the FIFO ----
   assign buf_wr_en = !fifo_empty;
   assign pop       = buf_wr_en && buf_wr_ready;

   // Present the head entry, forced to zero while nothing is queued.
   always_comb begin
      head_end    = 1'b0;
      buf_wr_adr  = '0;
      buf_wr_data = '0;
      if (!fifo_empty) begin
         {head_end, buf_wr_adr, buf_wr_data} = head_entry;
      end
   end

   // Tile completion pulse, running beat count and sticky overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tile_done     <= 1'b0;
         overflow      <= 1'b0;
         beats_written <= '0;
      end else begin
         tile_done <= pop && head_end;
         if (vld_p0 && !push_accepted) overflow <= 1'b1;
         if (pop) begin
            if (head_end) beats_written <= '0;
            else          beats_written <= beats_written + 16'd1;
         end
      end
   end

   // A full FIFO is observable only through push_accepted; keep the flag tied in.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_conv_out_buf_writer.sv
// Scoreboard bench for conv_out_buf_writer: a queue-level model of the
// buffer predicts accepted beats, drops, tile completion and beat counts.
module tb_conv_out_buf_writer;

   typedef struct {
      logic [15:0]  adr;
      logic [255:0] data;
      logic         last;
   } ent_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [255:0] in_data = '0;
   logic [15:0]  in_y_idx = '0;
   logic [15:0]  in_x_idx = '0;
   logic [15:0]  in_f_idx = '0;
   logic         in_add_end = 1'b0;
   logic [15:0]  of_in_2pow = 16'd5;
   logic [15:0]  ox_in_2pow = 16'd6;
   logic         buf_wr_ready = 1'b1;
   logic         buf_wr_en;
   logic [15:0]  buf_wr_adr;
   logic [255:0] buf_wr_data;
   logic         tile_done;
   logic         overflow;
   logic [15:0]  beats_written;

   int checks = 0;
   int errors = 0;
   int n_writes = 0;
   int n_done = 0;

   ent_t mq[$];
   ent_t sb[$];
   ent_t pend;
   bit   pend_v = 0;
   bit   exp_ovf = 0;
   bit   exp_done = 0;
   logic [15:0] exp_bw = '0;

   conv_out_buf_writer dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_y_idx      (in_y_idx),
      .in_x_idx      (in_x_idx),
      .in_f_idx      (in_f_idx),
      .in_add_end    (in_add_end),
      .of_in_2pow    (of_in_2pow),
      .ox_in_2pow    (ox_in_2pow),
      .buf_wr_ready  (buf_wr_ready),
      .buf_wr_en     (buf_wr_en),
      .buf_wr_adr    (buf_wr_adr),
      .buf_wr_data   (buf_wr_data),
      .tile_done     (tile_done),
      .overflow      (overflow),
      .beats_written (beats_written)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Row-major word index: rows of 2^(of+ox)/32 words, x groups of 32 pixels
   // each occupying 2^of words, one word per filter; taken mod 2^16.
   function automatic logic [15:0] ref_adr(input int y, input int x, input int f,
                                           input int of2, input int ox2);
      longint v;
      v = (longint'(y) - 1) * (longint'(1) << (of2 + ox2 - 5))
          + (longint'((x - 1) / 32) << of2) + longint'(f - 1);
      return v[15:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference model: a bounded queue of capacity 4, fed one cycle after the input.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         sb.delete();
         pend_v   = 0;
         exp_ovf  = 0;
         exp_done = 0;
         exp_bw   = '0;
      end else begin
         ent_t e;
         exp_done = 0;
         if (mq.size() > 0 && buf_wr_ready) begin
            e = mq.pop_front();
            if (e.last) begin
               exp_done = 1;
               exp_bw   = '0;
            end else begin
               exp_bw = exp_bw + 16'd1;
            end
         end
         if (pend_v) begin
            if (mq.size() < 4) begin
               mq.push_back(pend);
               sb.push_back(pend);
            end else begin
               exp_ovf = 1;
            end
         end
         pend_v = in_valid;
         if (in_valid) begin
            pend.adr  = ref_adr(int'(in_y_idx), int'(in_x_idx), int'(in_f_idx),
                                int'(of_in_2pow), int'(ox_in_2pow));
            pend.data = in_data;
            pend.last = in_add_end;
         end
      end
   end

   // Monitor: compare every presented write and the status outputs mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         check("rst_wr_en", {255'd0, buf_wr_en}, 256'd0);
         check("rst_adr", {240'd0, buf_wr_adr}, 256'd0);
         check("rst_data", buf_wr_data, 256'd0);
         check("rst_status", {253'd0, tile_done, overflow, |beats_written}, 256'd0);
      end else begin
         check("wr_en", {255'd0, buf_wr_en}, {255'd0, mq.size() != 0});
         if (buf_wr_en && buf_wr_ready) begin
            n_writes++;
            if (sb.size() == 0) begin
               check("unexpected_write", {240'd0, buf_wr_adr}, 256'd0);
            end else begin
               ent_t e;
               e = sb.pop_front();
               check("wr_adr", {240'd0, buf_wr_adr}, {240'd0, e.adr});
               check("wr_data", buf_wr_data, e.data);
            end
         end
         if (tile_done) n_done++;
         check("tile_done", {255'd0, tile_done}, {255'd0, exp_done});
         check("overflow", {255'd0, overflow}, {255'd0, exp_ovf});
         check("beats_written", {240'd0, beats_written}, {240'd0, exp_bw});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int y, input int x, input int f, input bit last);
      in_valid   = 1'b1;
      in_y_idx   = 16'(y);
      in_x_idx   = 16'(x);
      in_f_idx   = 16'(f);
      in_add_end = last;
      in_data    = rand256();
      step();
      in_valid   = 1'b0;
      in_add_end = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int w0;
      int d0;
      reset = 1'b0;
      idle(3);
      reset = 1'b1;
      idle(2);

      // Single beat: address 99, write strobe two edges after in_valid.
      buf_wr_ready = 1'b1;
      send(2, 33, 4, 1'b0);
      step();
      check("lat_wr_en", {255'd0, buf_wr_en}, 256'd1);
      check("adr_99", {240'd0, buf_wr_adr}, 256'd99);
      idle(4);

      // One full tile of 32 filters, addresses 0..31, one tile_done.
      d0 = n_done;
      w0 = n_writes;
      for (int f = 1; f <= 32; f++) send(1, 1, f, f == 32);
      idle(5);
      check("tile_writes", 256'(n_writes - w0), 256'd32);
      check("tile_done_cnt", 256'(n_done - d0), 256'd1);
      check("bw_after_tile", {240'd0, beats_written}, 256'd0);

      // Full FIFO with pop and push in the same cycle: nothing dropped.
      w0 = n_writes;
      buf_wr_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(3, 65, i + 1, 1'b0);
      buf_wr_ready = 1'b1;
      step();
      check("full_pushpop_ovf", {255'd0, overflow}, 256'd0);
      check("full_pushpop_en", {255'd0, buf_wr_en}, 256'd1);
      idle(8);
      check("full_pushpop_writes", 256'(n_writes - w0), 256'd5);
      check("no_ovf", {255'd0, overflow}, 256'd0);

      // Stall 10 cycles with 6 beats: 4 held, 2 dropped.
      w0 = n_writes;
      buf_wr_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(2, 1, i + 1, 1'b0);
      idle(4);
      buf_wr_ready = 1'b1;
      idle(8);
      check("stall_writes", 256'(n_writes - w0), 256'd4);
      check("ovf_sticky", {255'd0, overflow}, 256'd1);

      // Reset mid-tile with 3 entries queued: everything discarded.
      buf_wr_ready = 1'b0;
      send(1, 1, 1, 1'b0);
      send(1, 1, 2, 1'b0);
      send(1, 1, 3, 1'b1);
      idle(2);
      reset = 1'b0;
      #1;
      check("rst_async_en", {255'd0, buf_wr_en}, 256'd0);
      step();
      reset = 1'b1;
      buf_wr_ready = 1'b1;
      w0 = n_writes;
      d0 = n_done;
      idle(6);
      check("rst_no_writes", 256'(n_writes - w0), 256'd0);
      check("rst_no_done", 256'(n_done - d0), 256'd0);

      // Coordinate corners: first pixel maps to 0, y=0 wraps.
      send(1, 1, 1, 1'b0);
      step();
      check("adr_origin", {240'd0, buf_wr_adr}, 256'd0);
      idle(2);
      send(0, 1, 1, 1'b0);
      step();
      check("adr_y0_wrap", {240'd0, buf_wr_adr}, {240'd0, 16'hFFC0});
      idle(3);

      // Randomized traffic with random stalls across several tile geometries.
      for (int seg = 0; seg < 4; seg++) begin
         of_in_2pow = 16'($urandom_range(2, 6));
         ox_in_2pow = 16'($urandom_range(3, 7));
         for (int c = 0; c < 120; c++) begin
            buf_wr_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 7)
               send($urandom_range(1, 8), $urandom_range(1, 128),
                    $urandom_range(1, 1 << of_in_2pow), $urandom_range(0, 11) == 0);
            else
               idle(1);
         end
         buf_wr_ready = 1'b1;
         idle(8);
         check("sb_drained", 256'(sb.size()), 256'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_out_buf_writer.md
# conv_out_buf_writer

Consumer end of the conv output stream: takes the per-channel beats emitted by the conv output handler (data plus 1-based y/x/f indices and end-of-tile flag), computes the output-buffer word address, and drives the output-buffer write port through a small elastic FIFO. It sits between the conv output handler and the output buffer SRAM. It decouples the handler, which has no backpressure, from a write port that may stall.

## Interface
Parameters:
- pixels_in_row, 32, x-pixels packed per buffer word
- pixels_in_row_in_2pow, 5, log2(pixels_in_row)
- out_data_width, 256, beat/word width in bits
- fifo_depth, 4, elastic FIFO entries (power of 2)
- fifo_depth_in_2pow, 2, log2(fifo_depth)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; all state is cleared while low
- in_valid  in  1  beat present (the handler's valid_rowi_out_buf_adr)
- in_data  in  out_data_width  beat payload
- in_y_idx, in_x_idx, in_f_idx  in  16 each  1-based output coordinates
- in_add_end  in  1  last beat of tile; qualified by in_valid
- of_in_2pow, ox_in_2pow  in  16 each  log2 of tile OF and OX; stable for the whole tile
- buf_wr_ready  in  1  buffer accepts a write this cycle
- buf_wr_en  out  1  write strobe
- buf_wr_adr  out  16  word address
- buf_wr_data  out  out_data_width  word data
- tile_done  out  1  one-cycle pulse when the in_add_end beat has been written
- overflow  out  1  sticky: a beat arrived while the FIFO was full
- beats_written  out  16  writes completed since reset or the last tile_done

## Operation
- Stage A: on in_valid, register the data, the indices and the end flag, and set a_valid. Without in_valid, a_valid <= 0.
- Stage B: compute the address from the stage A registers, 16-bit, wrap mod 2^16:
  - adr = ((y-1) << (of_in_2pow+ox_in_2pow-pixels_in_row_in_2pow)) + (((x-1) >> pixels_in_row_in_2pow) << of_in_2pow) + (f-1)
  - Push {adr, data, end} into the FIFO when a_valid.
- FIFO: circular buffer of fifo_depth entries with wr_ptr and rd_ptr, each fifo_depth_in_2pow+1 bits wide.
  - full = (MSBs differ) and (LSBs equal).
  - empty = (pointers equal).
- Push while full:
  - The beat is dropped and overflow is set; it stays set until reset.
  - The pointers are unchanged.
- Write port:
  - buf_wr_en = !empty; buf_wr_adr and buf_wr_data come from the head entry (show-ahead).
  - The head is popped when buf_wr_en && buf_wr_ready.
- Simultaneous push and pop while full: the pop frees the slot, so the push is accepted and overflow is not set.
- Simultaneous push and pop while empty: not possible, because buf_wr_en is 0 when the FIFO is empty.
- beats_written increments on each pop.
- On a pop of an entry with end=1:
  - tile_done pulses in the next cycle.
  - beats_written resets to 0 in that same cycle; the end beat itself is not added.
- No state machine beyond the FIFO. The block accepts beats continuously; tile boundaries are marked only by end entries.

## Timing
- Reset values: buf_wr_en=0, buf_wr_adr=0, buf_wr_data=0, tile_done=0, overflow=0, beats_written=0, pointers=0, a_valid=0.
- Latency: if in_valid is high at edge t, the entry is in the FIFO after edge t+1, and buf_wr_en is high in the cycle following edge t+1.
- Throughput: 1 beat/cycle while buf_wr_ready stays high.
- buf_wr_adr and buf_wr_data hold stable while buf_wr_en=1 and buf_wr_ready=0.
- Reset mid-tile: in-flight beats are discarded, and no tile_done is produced for the aborted tile.
- of_in_2pow+ox_in_2pow >= pixels_in_row_in_2pow is required; behaviour for smaller sums is undefined.

## Structure
- A shared package (the codebase conv constants header) holds pixels_in_row, pixels_in_row_in_2pow, out_data_width and the address-width constant 16.
- One sub-module, out_wr_fifo: the parameterised show-ahead FIFO with full/empty flags. The address stage and the counters stay in the top level.

## Test plan
- of_in_2pow=5, ox_in_2pow=6, beat y=2, x=33, f=4, ready=1 -> buf_wr_adr = (1<<6)+(1<<5)+3 = 99; buf_wr_en high 2 cycles after in_valid.
- 32 back-to-back beats f=1..32, last with in_add_end, ready=1 -> 32 writes with addresses 0..31 in order, tile_done 1 cycle after the last write, beats_written returns to 0.
- ready=0 for 10 cycles while 6 beats arrive -> first 4 are held, next 2 dropped, overflow=1; ready=1 -> exactly 4 writes.
- FIFO full, ready=1 and in_valid same cycle -> push accepted, overflow stays 0, occupancy stays 4.
- Reset low for 1 cycle while 3 entries are queued -> buf_wr_en=0 immediately, no writes and no tile_done afterwards.
- y=1, x=1, f=1 -> adr 0; y=0 (illegal) -> adr wraps to 0xFFFF-based value, no hang.
